// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM control unit.
//   state_t      : main FSM state encoding (also exported on State for debug)
//   IMM_*        : ImmSrc codes; they coincide with the Op field encoding
//   CMD_* / ALU_*: data-processing cmd field values and ALUControl codes
//   COND_*       : Instr[31:28] condition codes
//   cond_check() : evaluates a condition code against {N,Z,C,V}
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // ImmSrc equals Op, so these double as the opcode class encodings.
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags = {N, Z, C, V}; 1111 (never) falls through to the default.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = ~z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = ~c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = ~n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = ~v;
      COND_HI: cond_check = c & ~z;
      COND_LS: cond_check = ~c | z;
      COND_GE: cond_check = (n == v);
      COND_LT: cond_check = (n != v);
      COND_GT: cond_check = ~z & (n == v);
      COND_LE: cond_check = z | (n != v);
      COND_AL: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle.
//   Inputs to control : Cond, Op, Funct, Rd (instruction register fields), ALUFlags
//   Outputs of control: write enables, mux selects, ImmSrc, RegSrc, ALUControl, State
// master = control unit side, slave = datapath side.
interface multicycle_control_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [3:0] State;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/cond_unit.sv
// Condition unit: NZCV flag register, CondEx decode and write-enable gating.
//   clk, reset        : clock, async active-high reset (clears flags)
//   cond_i            : instruction condition field
//   alu_flags_i       : {N,Z,C,V} from the ALU
//   rd_i              : destination register (R15 = PC)
//   flag_w_i          : [1] loads N,Z ; [0] loads C,V (only non-zero in EXEC states)
//   exec_i / aluwb_i  : FSM is in EXECR/EXECI / in ALUWB
//   next_pc_i, reg_w_i, mem_w_i, branch_i : ungated FSM enables
//   pc_write_o, reg_write_o, mem_write_o  : gated enables, forced low during reset
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [3:0] rd_i,
  input  logic [1:0] flag_w_i,
  input  logic       exec_i,
  input  logic       aluwb_i,
  input  logic       next_pc_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       branch_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_held_q, cond_held_d;
  logic       cond_ex, cond_gate, rd_is_pc, pcs;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      cond_held_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_held_q <= cond_held_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    flags_d     = flags_q;
    cond_held_d = cond_held_q;

    cond_ex = cond_check(cond_i, flags_q);

    if (flag_w_i[1] && cond_ex) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0] && cond_ex) flags_d[1:0] = alu_flags_i[1:0];

    // The flags may change on the edge ending EXEC; ALUWB must still be
    // gated by the condition as evaluated before that update.
    if (exec_i) cond_held_d = cond_ex;
    cond_gate = aluwb_i ? cond_held_q : cond_ex;

    rd_is_pc = (rd_i == 4'hF);
    pcs      = (rd_is_pc & reg_w_i) | branch_i;

    pc_write_o  = ~reset & (next_pc_i | (pcs & cond_gate));
    reg_write_o = ~reset & reg_w_i & cond_gate & ~rd_is_pc;
    mem_write_o = ~reset & mem_w_i & cond_gate;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM control unit: Moore main FSM, ALU decoder and instruction
// decode outputs; flag register and enable gating live in cond_unit.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (State -> FETCH, flags cleared,
//           write enables held low)
//   ctrl  : master side of multicycle_control_if (IR fields and ALU flags in,
//           datapath controls and debug State out)
module multicycle_control
  import arm_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master ctrl
);

  state_t     state_q, state_d;
  logic       next_pc, ir_write, reg_w, mem_w, branch, alu_op;
  logic       adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src;
  logic [1:0] alu_control, flag_w;
  logic [3:0] cmd;
  logic       exec_st, aluwb_st;

  // NOTE: async reset only touches the state register; all outputs are
  // decoded from it, so they settle to FETCH values as soon as reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    next_pc    = 1'b0;
    ir_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;

    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (ctrl.Op)
          IMM_MEM: state_d = S_MEMADR;
          IMM_DP:  state_d = ctrl.Funct[5] ? S_EXECI : S_EXECR;
          IMM_B:   state_d = S_BRANCH;
          default: state_d = S_FETCH;  // undefined op retires as a no-op
        endcase
      end
      S_MEMADR: begin
        state_d   = ctrl.Funct[0] ? S_MEMRD : S_MEMWR;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR: begin
        state_d = S_ALUWB;
        alu_op  = 1'b1;
      end
      S_EXECI: begin
        state_d   = S_ALUWB;
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: state_d = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  // ALU decoder. Unsupported cmds fall back to ADD and never write flags.
  always_comb begin
    cmd         = ctrl.Funct[4:1];
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        default: alu_control = ALU_ADD;
      endcase
      if (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_AND || cmd == CMD_ORR) begin
        flag_w[1] = ctrl.Funct[0];
        flag_w[0] = ctrl.Funct[0] & ((cmd == CMD_ADD) || (cmd == CMD_SUB));
      end
    end
  end

  assign exec_st  = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign aluwb_st = (state_q == S_ALUWB);

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (ctrl.Cond),
    .alu_flags_i (ctrl.ALUFlags),
    .rd_i        (ctrl.Rd),
    .flag_w_i    (flag_w),
    .exec_i      (exec_st),
    .aluwb_i     (aluwb_st),
    .next_pc_i   (next_pc),
    .reg_w_i     (reg_w),
    .mem_w_i     (mem_w),
    .branch_i    (branch),
    .pc_write_o  (ctrl.PCWrite),
    .reg_write_o (ctrl.RegWrite),
    .mem_write_o (ctrl.MemWrite)
  );

  assign ctrl.IRWrite    = ir_write & ~reset;
  assign ctrl.AdrSrc     = adr_src;
  assign ctrl.ALUSrcA    = alu_src_a;
  assign ctrl.ALUSrcB    = alu_src_b;
  assign ctrl.ResultSrc  = result_src;
  assign ctrl.ImmSrc     = ctrl.Op;
  assign ctrl.RegSrc     = {ctrl.Op == IMM_MEM, ctrl.Op == IMM_B};
  assign ctrl.ALUControl = alu_control;
  assign ctrl.State      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A reference model derives each
// instruction's state walk from its opcode, evaluates its condition once
// against model flags, and predicts every output cycle by cycle.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] m_flags;  // model {N,Z,C,V}

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] m_aluctl(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} for each state number.
  function automatic logic [5:0] m_mux(input int st);
    case (st)
      0, 1: return {1'b0, 1'b1, 2'b10, 2'b10};
      2:    return {1'b0, 1'b0, 2'b01, 2'b00};
      3:    return {1'b1, 1'b0, 2'b00, 2'b00};
      4:    return {1'b0, 1'b0, 2'b00, 2'b01};
      5:    return {1'b1, 1'b0, 2'b00, 2'b00};
      7:    return {1'b0, 1'b0, 2'b01, 2'b00};
      9:    return {1'b0, 1'b0, 2'b01, 2'b10};
      default: return 6'b0;
    endcase
  endfunction

  // Entered just after a rising edge with the DUT in FETCH; returns the same way.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] flags_in, input bit rand_flags);
    int seq[$];
    bit ok, sup;
    logic [7:0] got[9];
    logic [7:0] exp[9];
    string nm[9];
    nm = '{"State", "PCWrite", "IRWrite", "RegWrite", "MemWrite",
           "MuxSel", "ImmSrc", "RegSrc", "ALUControl"};
    seq = {0, 1};
    case (op)
      2'b01: begin
        seq.push_back(2);
        if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b00: begin seq.push_back(funct[5] ? 7 : 6); seq.push_back(8); end
      2'b10: seq.push_back(9);
      default: ;
    endcase
    ok  = m_cond(cond, m_flags);
    sup = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010) ||
          (funct[4:1] == 4'b0000) || (funct[4:1] == 4'b1100);
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    foreach (seq[k]) begin
      int st;
      bit wb;
      st = seq[k];
      wb = (st == 4) || (st == 8);
      bus.ALUFlags = rand_flags ? 4'($urandom) : flags_in;
      @(negedge clk);
      got[0] = 8'(bus.State);      exp[0] = 8'(st);
      got[1] = 8'(bus.PCWrite);    exp[1] = 8'((k == 0) || (st == 9 && ok) || (wb && ok && rd == 4'hF));
      got[2] = 8'(bus.IRWrite);    exp[2] = 8'(k == 0);
      got[3] = 8'(bus.RegWrite);   exp[3] = 8'(wb && ok && rd != 4'hF);
      got[4] = 8'(bus.MemWrite);   exp[4] = 8'(st == 5 && ok);
      got[5] = 8'({bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc});
      exp[5] = 8'(m_mux(st));
      got[6] = 8'(bus.ImmSrc);     exp[6] = 8'(op);
      got[7] = 8'(bus.RegSrc);     exp[7] = 8'({op == 2'b01, op == 2'b10});
      got[8] = 8'(bus.ALUControl); exp[8] = (st == 6 || st == 7) ? 8'(m_aluctl(funct[4:1])) : 8'h0;
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (got[i] !== exp[i]) begin
          n_err++;
          $display("FAIL %s (cond=%h op=%b funct=%b rd=%0d step %0d state %0d): got %0h expected %0h",
                   nm[i], cond, op, funct, rd, k, st, got[i], exp[i]);
        end
      end
      if ((st == 6 || st == 7) && ok && funct[0] && sup) begin
        m_flags[3:2] = bus.ALUFlags[3:2];
        if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010) m_flags[1:0] = bus.ALUFlags[1:0];
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'h0; bus.ALUFlags = 4'h0;
    m_flags = 4'b0000;
    #1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (bus.State !== 4'd0 || {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold: got state %0d enables %b expected state 0 enables 0000",
                 bus.State, {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
      end
      n_cmp++;
      if ({bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc} !== 6'b011010) begin
        n_err++;
        $display("FAIL reset_mux: got %b expected 011010",
                 {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ADDS R1,R2,#5 producing C=1
  task automatic test_adds();
    run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0010, 1'b0);
  endtask

  task automatic test_ldr();
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 1'b0);
  endtask

  // SUBS sets Z (taken BEQ), then SUBS clears Z (not taken BEQ)
  task automatic test_beq();
    run_instr(4'hE, 2'b00, 6'b100101, 4'd0, 4'b0100, 1'b0);
    run_instr(4'h0, 2'b10, 6'b101101, 4'd7, 4'b0000, 1'b0);
    run_instr(4'hE, 2'b00, 6'b100101, 4'd0, 4'b0000, 1'b0);
    run_instr(4'h0, 2'b10, 6'b101101, 4'd7, 4'b0000, 1'b0);
  endtask

  task automatic test_strne();
    run_instr(4'hE, 2'b00, 6'b100101, 4'd0, 4'b0100, 1'b0);
    run_instr(4'h1, 2'b01, 6'b011000, 4'd4, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'd5;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: got state %0d MemWrite %b expected state 5 MemWrite 1",
               bus.State, bus.MemWrite);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.State !== 4'd0 || {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_async: got state %0d enables %b expected state 0 enables 0000",
               bus.State, {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
    end
    m_flags = 4'b0000;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_hold: got state %0d MemWrite %b expected state 0 MemWrite 0",
               bus.State, bus.MemWrite);
    end
    reset = 1'b0;
    // After reset the flags are clear, so EQ must fail and NE must pass.
    run_instr(4'h0, 2'b01, 6'b011000, 4'd6, 4'b0000, 1'b0);
    run_instr(4'h1, 2'b01, 6'b011000, 4'd6, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] cond, cmd, rd;
      logic [1:0] op;
      logic       s, imm;
      cond = 4'($urandom);
      op   = 2'($urandom);
      cmd  = 4'($urandom);
      s    = 1'($urandom);
      imm  = 1'($urandom);
      rd   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      if (op == 2'b00 && !(cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100))
        s = 1'b0;
      run_instr(cond, op, {imm, cmd, s}, rd, 4'b0000, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_ldr();
    test_beq();
    test_strne();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
